// File: rtl/alu_pkg.sv
// alu_pkg: shared FSM states and constants for the ALU datapath blocks
package alu_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int WIDTH = 8;
  localparam logic [63:0] DIV0_QUOTIENT = '1;
endpackage

// File: rtl/borrow_lookahead_subtractor.sv
// borrow_lookahead_subtractor: a - b as a + ~b + 1 with flattened lookahead carries; borrow = ~carry_out
module borrow_lookahead_subtractor #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);
  logic [N-1:0] g, p;
  logic [N:0] c;
  always_comb begin
    g = a & ~b;
    p = a ^ ~b;
    c = '0;
    c[0] = 1'b1;
    for (int i = 0; i < N; i++) begin
      logic acc, run;
      acc = 1'b0;
      run = 1'b1;
      for (int j = i; j >= 0; j--) begin
        acc = acc | (run & g[j]);
        run = run & p[j];
      end
      c[i+1] = acc | run;
    end
  end
  assign diff = p ^ c[N-1:0];
  assign borrow = ~c[N];
endmodule

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: N-bit restoring divider, one quotient bit per cycle.
// Define SEQ_RESTORING_DIVIDER_SIGNED_EN for two's complement truncating division.
module seq_restoring_divider
  import alu_pkg::*;
#(
  parameter int N = WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);
  localparam int CW = (N > 2) ? $clog2(N) : 1;
  state_t state;
  logic [N:0] a, sh, diff, a_nx;
  logic [N-1:0] q, d, q_nx, dvd_mag, dvs_mag, quot_res, rem_res;
  logic [CW-1:0] cnt;
  logic borrow;
  borrow_lookahead_subtractor #(.N(N + 1)) u_sub (
    .a(sh),
    .b({1'b0, d}),
    .diff(diff),
    .borrow(borrow)
  );
  assign sh = {a[N-1:0], q[N-1]};
  assign a_nx = borrow ? sh : diff;
  assign q_nx = {q[N-2:0], ~borrow};
`ifdef SEQ_RESTORING_DIVIDER_SIGNED_EN
  logic neg_q, neg_r;
  assign dvd_mag = dividend[N-1] ? -dividend : dividend;
  assign dvs_mag = divisor[N-1] ? -divisor : divisor;
  assign quot_res = neg_q ? -q_nx : q_nx;
  assign rem_res = neg_r ? -a_nx[N-1:0] : a_nx[N-1:0];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == IDLE && start) begin
      neg_q <= dividend[N-1] ^ divisor[N-1];
      neg_r <= dividend[N-1];
    end
`else
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
  assign quot_res = q_nx;
  assign rem_res = a_nx[N-1:0];
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      a <= '0;
      q <= '0;
      d <= '0;
      cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          busy <= 1'b1;
          if (divisor == '0) begin
            state <= DONE;
            done <= 1'b1;
            quotient <= DIV0_QUOTIENT[N-1:0];
            remainder <= dividend;
            div_by_zero <= 1'b1;
          end else begin
            state <= RUN;
            a <= '0;
            q <= dvd_mag;
            d <= dvs_mag;
            cnt <= CW'(N - 1);
          end
        end
        RUN: begin
          a <= a_nx;
          q <= q_nx;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            state <= DONE;
            done <= 1'b1;
            quotient <= quot_res;
            remainder <= rem_res;
            div_by_zero <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
          done <= 1'b0;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: directed vectors for the restoring divider (either build)
module tb_seq_restoring_divider;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [7:0] dividend = '0, divisor = '0;
  logic busy, done, div_by_zero;
  logic [7:0] quotient, remainder;
  int vectors = 0, miscompares = 0;
  seq_restoring_divider #(.N(8)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run(input logic [7:0] x, input logic [7:0] y, input logic [7:0] eq,
                     input logic [7:0] er, input logic ez, input int lat);
    int n;
    @(negedge clk);
    dividend = x;
    divisor = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    check("busy_rise", busy, 1'b1);
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, lat);
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
    check("div_by_zero", div_by_zero, ez);
    @(negedge clk);
    check("done_pulse", done, 1'b0);
    check("busy_fall", busy, 1'b0);
    check("quotient_held", quotient, eq);
  endtask
  initial begin
    int first, pulses;
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_quotient", quotient, 8'h00);
    check("rst_remainder", remainder, 8'h00);
    check("rst_dbz", div_by_zero, 1'b0);
    rst = 1'b0;
    run(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 9);
    run(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 9);
    run(8'd5, 8'd200, 8'd0, 8'd5, 1'b0, 9);
    run(8'd77, 8'd0, 8'hFF, 8'd77, 1'b1, 1);
`ifdef SEQ_RESTORING_DIVIDER_SIGNED_EN
    run(8'hF9, 8'd2, 8'hFD, 8'hFF, 1'b0, 9);
    run(8'd7, 8'hFE, 8'hFD, 8'd1, 1'b0, 9);
    run(8'h80, 8'hFF, 8'h80, 8'd0, 1'b0, 9);
`else
    run(8'd200, 8'd13, 8'd15, 8'd5, 1'b0, 9);
    run(8'd128, 8'd255, 8'd0, 8'd128, 1'b0, 9);
`endif
    // a second start mid-run must be ignored
    @(negedge clk);
    dividend = 8'd100;
    divisor = 8'd7;
    start = 1'b1;
    @(negedge clk);
    first = 0;
    pulses = 0;
    for (int n = 1; n <= 14; n++) begin
      if (done) begin
        pulses++;
        if (first == 0) first = n;
      end
      start = (n == 3);
      if (n == 3) begin
        dividend = 8'd50;
        divisor = 8'd5;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("ignored_lat", first, 9);
    check("ignored_pulses", pulses, 1);
    check("ignored_quot", quotient, 8'd14);
    check("ignored_rem", remainder, 8'd2);
    // reset mid-run discards the operation
    dividend = 8'd100;
    divisor = 8'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_quot", quotient, 8'h00);
    check("midrst_rem", remainder, 8'h00);
    check("midrst_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    run(8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 9);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/seq_restoring_divider.md
# seq_restoring_divider

Multi-cycle N-bit integer divider for the ALU datapath. It computes quotient and remainder by restoring division, one quotient bit per cycle. Each trial subtraction runs on a combinational borrow-lookahead subtractor, which is the subtraction counterpart of the team's carry-lookahead adder. A start/busy/done handshake connects it to the ALU sequencer.

## Interface
- `N`, 8, operand and result width in bits; N ≥ 2.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request a division; sampled only in IDLE.
- `dividend` input N: numerator; captured on an accepted `start`.
- `divisor` input N: denominator; captured on an accepted `start`.
- `busy` output 1: high in RUN and DONE; reset 0.
- `done` output 1: one-cycle pulse when results are valid; reset 0.
- `quotient` output N: registered and held until the next result; reset 0.
- `remainder` output N: registered and held until the next result; reset 0.
- `div_by_zero` output 1: registered alongside `done`; held with the results; reset 0.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE with `start`=1 and `divisor`≠0:
  - Latch the operand magnitudes: A = 0 (N+1 bits), Q = dividend, D = divisor.
  - Load counter = N-1.
  - Go to RUN.
- IDLE with `start`=1 and `divisor`=0:
  - Go to DONE.
  - Registered result: `quotient` = all ones, `remainder` = `dividend` (raw), `div_by_zero` = 1.
- RUN, each cycle:
  - Shift {A,Q} left by 1.
  - T = A_shifted − {0,D}, computed on the subtractor.
  - If no borrow: A = T and Q[0] = 1. Otherwise keep A_shifted and set Q[0] = 0.
  - Decrement the counter.
  - When the counter is 0 this cycle, register the final `quotient`/`remainder` with `div_by_zero`=0 and go to DONE.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- `start` while in RUN or DONE is ignored. There is no queuing, and operands are not re-sampled.
- `quotient`/`remainder`/`div_by_zero` change only on entry to DONE. They are stable at all other times.
- Results satisfy dividend = quotient·divisor + remainder, with remainder < divisor (unsigned build).
- `rst` asserted at any time, including mid-RUN:
  - All state returns to IDLE.
  - All outputs and internal registers clear to 0 immediately.
  - The in-flight operation is discarded.

## Timing
- Accepted `start` at edge k means RUN spans edges k+1 … k+N, and `done`=1 in the cycle after edge k+N. Latency is N+1 cycles from start to done.
- Divide-by-zero: `done`=1 in the cycle after edge k, so latency is 1.
- Back-to-back operation: `start` may be re-asserted in the first IDLE cycle after DONE. Minimum issue interval is N+2 cycles.
- `busy` rises the cycle after an accepted `start` and falls the cycle after `done`.
- Trial subtract plus mux is the critical path. It is one N+1-bit subtraction per cycle.

## Configuration
- Macro: `SEQ_RESTORING_DIVIDER_SIGNED_EN`.
- Defined: operands and results are two's complement.
  - Magnitudes are taken at capture.
  - On entry to DONE, the quotient is negated if the operand signs differ, and the remainder takes the sign of the dividend (truncating division).
  - Overflow case −2^(N−1)/−1 gives quotient = −2^(N−1) (wraps) and remainder = 0.
  - Divide-by-zero behaviour is unchanged.
- Undefined: unsigned only, with no sign logic. Latency is identical in both builds.

## Structure
- Shared package `alu_pkg` holds:
  - the FSM state enum (IDLE, RUN, DONE);
  - the default width constant;
  - the divide-by-zero quotient constant (all ones).
- One sub-module: `borrow_lookahead_subtractor`, parameter N+1. It computes difference and borrow-out using lookahead generate/propagate on A and ~B with carry-in 1.
- The counter is $clog2(N) bits wide.

## Test plan
- N=8, unsigned: 100/7 → `done` at cycle 9 after start, `quotient`=14, `remainder`=2, `div_by_zero`=0.
- 255/1 → `quotient`=255, `remainder`=0. 5/200 → `quotient`=0, `remainder`=5.
- 77/0 → `done` the cycle after start, `div_by_zero`=1, `quotient`=0xFF, `remainder`=77.
- 100/7 started, then `start` with 50/5 at cycle 3 → ignored. Result is still 14 r 2 and only one `done` pulse occurs.
- `rst` pulsed at cycle 4 of RUN → outputs 0 and `busy`=0 immediately. A following 9/3 gives 3 r 0 with normal latency.
- SIGNED build:
  - −7/2 → `quotient`=0xFD, `remainder`=0xFF.
  - 7/−2 → `quotient`=0xFD, `remainder`=1.
  - −128/−1 → `quotient`=0x80, `remainder`=0.
